uart_matrix_parser: RTL and testbench



---
 rtl/uart_matrix_parser.sv | 183 ++++++++++++++++++
 tb/tb_uart_matrix_parser.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_parser.sv
// Parses ASCII "rows cols e0 e1 ..." from the UART RX into one flattened matrix write.
// Optional inter-byte timeout (error code 4) is enabled by defining PARSER_TIMEOUT_EN.
module uart_matrix_parser #(
    parameter int DATA_WIDTH     = 9,
    parameter int MAX_DIM        = 5,
    parameter int MAX_VAL        = 511,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     busy,
    output logic                     wr_en,
    output logic [2:0]               wr_row,
    output logic [2:0]               wr_col,
    output logic [25*DATA_WIDTH-1:0] wr_data,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               err_code
);

    localparam int ACC_W = DATA_WIDTH + 4;
    localparam int BUS_W = 25 * DATA_WIDTH;

    generate
        if (MAX_DIM > 5 || MAX_DIM < 1 || MAX_VAL > (2**DATA_WIDTH) - 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("uart_matrix_parser: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, GET_ROW, GET_COL, GET_ELEM, COMMIT, ERROR} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             have_digit;
    logic [4:0]       elem_cnt;
    logic [2:0]       rows;
    logic [2:0]       cols;
    logic [BUS_W-1:0] elem_buf;
    logic [BUS_W-1:0] buf_next;
    logic [ACC_W-1:0] acc_next;
    logic [5:0]       total;
    logic             is_digit;
    logic             is_delim;
    logic             dim_ok;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign acc_next = acc * ACC_W'(10) + ACC_W'(rx_data[3:0]);
    assign dim_ok   = !ovf && (acc >= ACC_W'(1)) && (acc <= ACC_W'(MAX_DIM));
    assign total    = {3'b000, rows} * {3'b000, cols};

    // The buffer as it will look once the current token is stored, so the final
    // element can go straight onto wr_data in the same cycle it is stored.
    always_comb begin
        buf_next = elem_buf;
        buf_next[int'(elem_cnt)*DATA_WIDTH +: DATA_WIDTH] = acc[DATA_WIDTH-1:0];
    end

`ifdef PARSER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == GET_ROW || state == GET_COL || state == GET_ELEM) && !rx_valid) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            ovf        <= 1'b0;
            have_digit <= 1'b0;
            elem_cnt   <= '0;
            rows       <= '0;
            cols       <= '0;
            elem_buf   <= '0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= GET_ROW;
                        busy       <= 1'b1;
                        elem_buf   <= '0;
                        err_code   <= '0;
                        acc        <= '0;
                        ovf        <= 1'b0;
                        have_digit <= 1'b0;
                        elem_cnt   <= '0;
                    end
                end
                GET_ROW, GET_COL, GET_ELEM: begin
                    if (rx_valid) begin
                        if (is_digit) begin
                            have_digit <= 1'b1;
                            // Freeze the accumulator once it overflows so it can never wrap back into range.
                            if (!ovf) begin
                                acc <= acc_next;
                                if (acc_next > ACC_W'(MAX_VAL)) ovf <= 1'b1;
                            end
                        end else if (is_delim) begin
                            if (have_digit) begin
                                acc        <= '0;
                                ovf        <= 1'b0;
                                have_digit <= 1'b0;
                                if (state == GET_ELEM) begin
                                    if (ovf) begin
                                        state    <= ERROR;
                                        err      <= 1'b1;
                                        err_code <= 3'd3;
                                    end else begin
                                        elem_buf <= buf_next;
                                        elem_cnt <= elem_cnt + 5'd1;
                                        if ({1'b0, elem_cnt} + 6'd1 == total) begin
                                            state   <= COMMIT;
                                            wr_en   <= 1'b1;
                                            done    <= 1'b1;
                                            wr_row  <= rows;
                                            wr_col  <= cols;
                                            wr_data <= buf_next;
                                        end
                                    end
                                end else if (!dim_ok) begin
                                    state    <= ERROR;
                                    err      <= 1'b1;
                                    err_code <= 3'd2;
                                end else if (state == GET_ROW) begin
                                    rows  <= acc[2:0];
                                    state <= GET_COL;
                                end else begin
                                    cols     <= acc[2:0];
                                    elem_cnt <= '0;
                                    state    <= GET_ELEM;
                                end
                            end
                        end else begin
                            state    <= ERROR;
                            err      <= 1'b1;
                            err_code <= 3'd1;
                        end
                    end
`ifdef PARSER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state    <= ERROR;
                        err      <= 1'b1;
                        err_code <= 3'd4;
                    end
`endif
                end
                COMMIT, ERROR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_matrix_parser.sv
// Scoreboard bench for uart_matrix_parser: directed ASCII streams, expected writes/errors queued
// by the stimulus and checked by an independent monitor whenever the DUT strobes an output.
module tb_uart_matrix_parser;

    localparam int DW    = 9;
    localparam int BUS_W = 25 * DW;

    typedef logic [BUS_W-1:0] word_t;

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [2:0] rows;
        logic [2:0] cols;
        word_t      data;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       busy;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    word_t      wr_data;
    logic       done;
    logic       err;
    logic [2:0] err_code;

    int    tests_run    = 0;
    int    tests_failed = 0;
    exp_t  sb[$];
    exp_t  mon_e;
    word_t d;

    uart_matrix_parser #(
        .DATA_WIDTH    (DW),
        .MAX_DIM       (5),
        .MAX_VAL       (511),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .done    (done),
        .err     (err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic void check_output(input string name, input word_t actual, input word_t expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endfunction

    function automatic void push_wr(input int r, input int c, input word_t data);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = 3'd0;
        e.rows   = 3'(r);
        e.cols   = 3'(c);
        e.data   = data;
        sb.push_back(e);
    endfunction

    function automatic void push_err(input int code);
        exp_t e;
        e.is_err = 1'b1;
        e.code   = 3'(code);
        e.rows   = 3'd0;
        e.cols   = 3'd0;
        e.data   = '0;
        sb.push_back(e);
    endfunction

    // Monitor: every output strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (wr_en || err || done)) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_output: wr_en=%0b err=%0b done=%0b, expected no output", wr_en, err, done);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    check_output("err_pulse", word_t'(err), word_t'(1'b1));
                    check_output("err_code", word_t'(err_code), word_t'(mon_e.code));
                    check_output("no_wr_on_err", word_t'(wr_en), word_t'(1'b0));
                end else begin
                    check_output("wr_en", word_t'(wr_en), word_t'(1'b1));
                    check_output("done", word_t'(done), word_t'(1'b1));
                    check_output("no_err_on_wr", word_t'(err), word_t'(1'b0));
                    check_output("wr_row", word_t'(wr_row), word_t'(mon_e.rows));
                    check_output("wr_col", word_t'(wr_col), word_t'(mon_e.cols));
                    check_output("wr_data", wr_data, mon_e.data);
                end
                check_output("busy_at_output", word_t'(busy), word_t'(1'b1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_start(input bit with_byte, input logic [7:0] b);
        start = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_data  = b;
        end
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick();
        check_output("wait_idle_timeout", word_t'(busy), word_t'(1'b0));
    endtask

    task automatic apply_stimulus(input string s, input bit expect_wr);
        send_str(s);
        if (expect_wr) begin
            check_output("wr_latency", word_t'(wr_en), word_t'(1'b1));
            tick();
            check_output("busy_drop", word_t'(busy), word_t'(1'b0));
            check_output("wr_one_cycle", word_t'(wr_en), word_t'(1'b0));
        end else begin
            wait_idle();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"}, word_t'(busy), '0);
        check_output({tag, "_strobes"}, word_t'({wr_en, done, err}), '0);
        check_output({tag, "_err_code"}, word_t'(err_code), '0);
        check_output({tag, "_wr_dims"}, word_t'({wr_row, wr_col}), '0);
        check_output({tag, "_wr_data"}, wr_data, '0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 2x3 matrix; a start pulse mid-parse must be ignored
        do_start(1'b0, 8'h00);
        check_output("busy_after_start", word_t'(busy), word_t'(1'b1));
        d = '0;
        for (int k = 0; k < 6; k++) d[k*DW +: DW] = DW'(k + 1);
        push_wr(2, 3, d);
        send_str("2 3 ");
        start = 1'b1;
        tick();
        start = 1'b0;
        apply_stimulus("1 2 3 4 5 6\n", 1'b1);

        // collapsed delimiters and leading zeros
        do_start(1'b0, 8'h00);
        d = '0;
        d[DW-1:0] = DW'(7);
        push_wr(1, 1, d);
        apply_stimulus("  1\015\n1   007 ", 1'b1);

        do_start(1'b0, 8'h00);
        push_err(2);
        apply_stimulus("6 2 ", 1'b0);

        do_start(1'b0, 8'h00);
        push_err(2);
        apply_stimulus("0 ", 1'b0);

        do_start(1'b0, 8'h00);
        push_err(3);
        apply_stimulus("1 2 511 512 ", 1'b0);

        do_start(1'b0, 8'h00);
        push_err(3);
        apply_stimulus("1 1 99999 ", 1'b0);

        do_start(1'b0, 8'h00);
        push_err(1);
        apply_stimulus("2 2 1 a", 1'b0);
        repeat (5) tick();
        check_output("err_code_held", word_t'(err_code), word_t'(3'd1));
        check_output("wr_row_held", word_t'(wr_row), word_t'(3'd1));
        check_output("wr_col_held", word_t'(wr_col), word_t'(3'd1));
        d = '0;
        d[DW-1:0] = DW'(7);
        check_output("wr_data_held", wr_data, d);

        do_start(1'b0, 8'h00);
        check_output("err_code_cleared", word_t'(err_code), word_t'(3'd0));
        d = '0;
        d[DW-1:0] = DW'(9);
        push_wr(1, 1, d);
        apply_stimulus("1 1 9 ", 1'b1);

        // bytes in IDLE are ignored, including one coincident with start
        send_str("7 7 ");
        check_output("idle_ignores_rx", word_t'(busy), word_t'(1'b0));
        do_start(1'b1, "5");
        d = '0;
        d[DW-1:0] = DW'(3);
        push_wr(1, 1, d);
        apply_stimulus("1 1 3 ", 1'b1);

        // reset mid-stream discards the partial matrix
        do_start(1'b0, 8'h00);
        send_str("3 3 1 2 ");
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_output("idle_after_reset", word_t'(busy), word_t'(1'b0));

        do_start(1'b0, 8'h00);
        d = '0;
        d[DW-1:0]  = DW'(4);
        d[2*DW-1:DW] = DW'(5);
        push_wr(1, 2, d);
        apply_stimulus("1 2 4 5\n", 1'b1);

`ifdef PARSER_TIMEOUT_EN
        do_start(1'b0, 8'h00);
        push_err(4);
        send_str("2 ");
        wait_idle();
        check_output("timeout_code", word_t'(err_code), word_t'(3'd4));
`endif

        repeat (3) tick();
        check_output("scoreboard_empty", word_t'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
